// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over 3-5 cycles
// with memory wait states, fetch stall, illegal-opcode trap and timeout fault.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             stall,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_2_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    ILLEGAL  = 4'd12,
    FAULT    = 4'd13
  } state_t;

  localparam logic [31:0] TO_LAST = (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [31:0]      wait_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             waiting, timeout;

  always_comb begin
    waiting = 1'b0;
    case (state_q)
      FETCH:          waiting = !stall && !mem_ready;
      MEM_RD, MEM_WR: waiting = !mem_ready;
      default:        waiting = 1'b0;
    endcase
  end

  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      // Any state change clears the counter, which covers entry into every memory state
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 32'd1;
      if (instr_done)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = !stall;
        alu_src_b = 2'b01;
        ir_write  = mem_ready && !stall;
        pc_write  = mem_ready && !stall;
        if (mem_ready && !stall) state_d = DECODE;
        else if (timeout)        state_d = FAULT;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'h00:        state_d = EXEC;
          6'h08:        state_d = ADDI_EX;
          6'h04:        state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h23, 6'h2B: state_d = MEM_ADDR;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'h23) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_d = MEM_WB;
        else if (timeout) state_d = FAULT;
      end
      MEM_WB: begin
        mem_2_reg  = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)    state_d = FETCH;
        else if (timeout) state_d = FAULT;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = FETCH;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  assign fault   = (state_q == FAULT);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle state and control
// vector checks against hand-written expectations, with MEM_TIMEOUT=4.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        stall;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_2_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        instr_done, illegal_op, fault;
  logic [3:0]  state;
  logic [31:0] retired;
  logic [18:0] ctrl;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // {pw pwc iod mrd mwr irw m2r rdst rw asa} {asb} {aop} {psrc} {done ill flt}
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, instr_done, illegal_op, fault};

  localparam logic [18:0] C_FSTALL = 19'b0000000000_01_00_00_000;
  localparam logic [18:0] C_FWAIT  = 19'b0001000000_01_00_00_000;
  localparam logic [18:0] C_FGO    = 19'b1001010000_01_00_00_000;
  localparam logic [18:0] C_DEC    = 19'b0000000000_11_00_00_000;
  localparam logic [18:0] C_MADDR  = 19'b0000000001_10_00_00_000;
  localparam logic [18:0] C_MRD    = 19'b0011000000_00_00_00_000;
  localparam logic [18:0] C_MWB    = 19'b0000001010_00_00_00_100;
  localparam logic [18:0] C_MWRW   = 19'b0010100000_00_00_00_000;
  localparam logic [18:0] C_MWRD   = 19'b0010100000_00_00_00_100;
  localparam logic [18:0] C_EXEC   = 19'b0000000001_00_10_00_000;
  localparam logic [18:0] C_RWB    = 19'b0000000110_00_00_00_100;
  localparam logic [18:0] C_BR     = 19'b0100000001_00_01_01_100;
  localparam logic [18:0] C_JMP    = 19'b1000000000_00_00_10_100;
  localparam logic [18:0] C_AEX    = 19'b0000000001_10_00_00_000;
  localparam logic [18:0] C_AWB    = 19'b0000000010_00_00_00_100;
  localparam logic [18:0] C_ILL    = 19'b0000000000_00_00_00_010;
  localparam logic [18:0] C_FLT    = 19'b0000000000_00_00_00_001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then check the Moore/qualified outputs of that cycle
  task automatic step(input string tag, input logic [5:0] op, input logic mr,
                      input logic st, input logic [3:0] es, input logic [18:0] ec);
    @(negedge clk);
    opcode = op; mem_ready = mr; stall = st;
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
    chk({tag, ".ctrl"}, {13'd0, ctrl}, {13'd0, ec});
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0; stall = 1'b1;
    @(negedge clk); #1;
    chk("reset.state", {28'd0, state}, 32'd0);
    chk("reset.ctrl", {13'd0, ctrl}, {13'd0, C_FSTALL});
    chk("reset.retired", retired, 32'd0);
    rst = 1'b0;

    // R-type
    step("r.f",  6'h00, 1'b1, 1'b0, 4'd0, C_FGO);
    step("r.d",  6'h00, 1'b1, 1'b0, 4'd1, C_DEC);
    step("r.ex", 6'h00, 1'b1, 1'b0, 4'd6, C_EXEC);
    step("r.wb", 6'h00, 1'b1, 1'b0, 4'd7, C_RWB);

    // Fetch waiting on memory, then LW with 3 read wait cycles
    step("lw.fw0", 6'h23, 1'b0, 1'b0, 4'd0, C_FWAIT);
    chk("r.retired", retired, 32'd1);
    step("lw.fw1", 6'h23, 1'b0, 1'b0, 4'd0, C_FWAIT);
    step("lw.f",   6'h23, 1'b1, 1'b0, 4'd0, C_FGO);
    step("lw.d",   6'h23, 1'b1, 1'b0, 4'd1, C_DEC);
    step("lw.a",   6'h23, 1'b1, 1'b0, 4'd2, C_MADDR);
    step("lw.rd0", 6'h23, 1'b0, 1'b0, 4'd3, C_MRD);
    step("lw.rd1", 6'h23, 1'b0, 1'b0, 4'd3, C_MRD);
    step("lw.rd2", 6'h23, 1'b0, 1'b0, 4'd3, C_MRD);
    step("lw.rd3", 6'h23, 1'b1, 1'b0, 4'd3, C_MRD);
    step("lw.wb",  6'h23, 1'b1, 1'b0, 4'd4, C_MWB);

    // BEQ then J
    step("beq.f", 6'h04, 1'b1, 1'b0, 4'd0, C_FGO);
    chk("lw.retired", retired, 32'd2);
    step("beq.d", 6'h04, 1'b1, 1'b0, 4'd1, C_DEC);
    step("beq.b", 6'h04, 1'b1, 1'b0, 4'd8, C_BR);
    step("j.f",   6'h02, 1'b1, 1'b0, 4'd0, C_FGO);
    step("j.d",   6'h02, 1'b1, 1'b0, 4'd1, C_DEC);
    step("j.j",   6'h02, 1'b1, 1'b0, 4'd9, C_JMP);

    // ADDI
    step("addi.f",  6'h08, 1'b1, 1'b0, 4'd0, C_FGO);
    chk("j.retired", retired, 32'd4);
    step("addi.d",  6'h08, 1'b1, 1'b0, 4'd1, C_DEC);
    step("addi.ex", 6'h08, 1'b1, 1'b0, 4'd10, C_AEX);
    step("addi.wb", 6'h08, 1'b1, 1'b0, 4'd11, C_AWB);

    // Illegal opcode
    step("ill.f", 6'h3F, 1'b1, 1'b0, 4'd0, C_FGO);
    chk("addi.retired", retired, 32'd5);
    step("ill.d", 6'h3F, 1'b1, 1'b0, 4'd1, C_DEC);
    step("ill.t", 6'h3F, 1'b1, 1'b0, 4'd12, C_ILL);

    // Stall in FETCH: no strobes, no counting even with memory idle
    step("st.0", 6'h2B, 1'b0, 1'b1, 4'd0, C_FSTALL);
    chk("ill.retired", retired, 32'd5);
    step("st.1", 6'h2B, 1'b0, 1'b1, 4'd0, C_FSTALL);
    step("st.2", 6'h2B, 1'b0, 1'b1, 4'd0, C_FSTALL);
    step("st.3", 6'h2B, 1'b1, 1'b1, 4'd0, C_FSTALL);
    step("st.4", 6'h2B, 1'b1, 1'b1, 4'd0, C_FSTALL);

    // SW with memory never ready -> FAULT after 4 waiting cycles
    step("sw.f",   6'h2B, 1'b1, 1'b0, 4'd0, C_FGO);
    step("sw.d",   6'h2B, 1'b1, 1'b0, 4'd1, C_DEC);
    step("sw.a",   6'h2B, 1'b0, 1'b0, 4'd2, C_MADDR);
    step("sw.w0",  6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("sw.w1",  6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("sw.w2",  6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("sw.w3",  6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("flt.0",  6'h2B, 1'b1, 1'b0, 4'd13, C_FLT);
    step("flt.1",  6'h2B, 1'b1, 1'b0, 4'd13, C_FLT);
    chk("flt.retired", retired, 32'd5);

    // Asynchronous reset clears fault and counter without a clock edge
    @(negedge clk);
    rst = 1'b1; stall = 1'b1; #1;
    chk("rst2.state", {28'd0, state}, 32'd0);
    chk("rst2.fault", {31'd0, fault}, 32'd0);
    chk("rst2.retired", retired, 32'd0);
    rst = 1'b0;

    // SW where mem_ready arrives on the deciding cycle: ready beats timeout
    step("sw2.f",  6'h2B, 1'b1, 1'b0, 4'd0, C_FGO);
    step("sw2.d",  6'h2B, 1'b1, 1'b0, 4'd1, C_DEC);
    step("sw2.a",  6'h2B, 1'b1, 1'b0, 4'd2, C_MADDR);
    step("sw2.w0", 6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("sw2.w1", 6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("sw2.w2", 6'h2B, 1'b0, 1'b0, 4'd5, C_MWRW);
    step("sw2.w3", 6'h2B, 1'b1, 1'b0, 4'd5, C_MWRD);
    step("end.f",  6'h00, 1'b0, 1'b1, 4'd0, C_FSTALL);
    chk("sw2.retired", retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
